// File: rtl/bram_player.sv
// Stimulus playback buffer: micro fills a dual-port RAM, the DSP side streams
// one word per play_ce in one-shot or looped mode.
module bram_player #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int DATA_W = 11
) (
  input  logic              clockdsp,
  input  logic              soft_reset,
  input  logic              play_wr_en_from_micro,
  input  logic [ADDR_W-1:0] play_wr_addr_from_micro,
  input  logic [31:0]       play_wr_data_from_micro,
  input  logic              play_start_from_micro,
  input  logic              play_stop_from_micro,
  input  logic [ADDR_W-1:0] play_last_addr_from_micro,
  input  logic              play_loop_from_micro,
  input  logic              play_ce,
  output logic [DATA_W-1:0] play_data,
  output logic              play_valid,
  output logic              play_busy,
  output logic              play_done,
  output logic [15:0]       play_passes
);

  // state | meaning
  // IDLE  | stopped or after reset; waiting for start
  // PLAY  | one RAM read per play_ce, address advancing through the table
  // DONE  | one-shot table finished; waiting for start or stop
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         passes_q, passes_d;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                rd_en;

  // Only the low DATA_W bits of a word ever reach play_data, so only those are stored.
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                unused_wr_hi;
  assign unused_wr_hi = ^play_wr_data_from_micro[31:DATA_W];

  assign rd_en = (state_q == S_PLAY) && play_ce;

  always_ff @(posedge clockdsp) begin
    if (play_wr_en_from_micro)
      mem_q[play_wr_addr_from_micro] <= play_wr_data_from_micro[DATA_W-1:0];
  end

  // Separate process from the write, so a same-address collision reads the old word.
  always_ff @(posedge clockdsp) begin
    if (soft_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_en;
      if (rd_en) data_q <= mem_q[addr_q];
    end
  end

  always_ff @(posedge clockdsp) begin
    if (soft_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      passes_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      passes_q <= passes_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    passes_d = passes_q;
    if (play_stop_from_micro) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end else if (play_start_from_micro) begin
      state_d  = S_PLAY;
      addr_d   = '0;
      passes_d = '0;
    end else if (rd_en) begin
      // Equality (not <) so a lowered last_addr runs on through the natural wrap.
      if (addr_q == play_last_addr_from_micro) begin
        if (passes_q != 16'hFFFF) passes_d = passes_q + 16'd1;
        addr_d = '0;
        if (!play_loop_from_micro) state_d = S_DONE;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    play_busy = (state_q == S_PLAY);
    play_done = (state_q == S_DONE);
  end

  assign play_data   = data_q;
  assign play_valid  = valid_q;
  assign play_passes = passes_q;

endmodule

// File: tb/tb_bram_player.sv
// Directed bench for bram_player: a behavioural model is checked every cycle,
// and the captured output streams are pinned against hand-computed tables.
module tb_bram_player;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int DATA_W = 11;
  localparam int M_IDLE = 0, M_PLAY = 1, M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wa = '0;
  logic [31:0]       wd = '0;
  logic              start = 1'b0, stop = 1'b0, loop_m = 1'b0, ce = 1'b0;
  logic [ADDR_W-1:0] last = '0;
  logic [DATA_W-1:0] play_data;
  logic              play_valid, play_busy, play_done;
  logic [15:0]       play_passes;

  bram_player #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clockdsp(clk), .soft_reset(rst),
    .play_wr_en_from_micro(wr_en), .play_wr_addr_from_micro(wa),
    .play_wr_data_from_micro(wd), .play_start_from_micro(start),
    .play_stop_from_micro(stop), .play_last_addr_from_micro(last),
    .play_loop_from_micro(loop_m), .play_ce(ce),
    .play_data(play_data), .play_valid(play_valid), .play_busy(play_busy),
    .play_done(play_done), .play_passes(play_passes)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit chk_en = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: table playback expressed with integers and an associative RAM.
  logic [31:0]       m_mem [int];
  int                m_mode = M_IDLE, m_addr = 0, m_passes = 0;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] w;
    if (rst) begin
      m_mode = M_IDLE; m_addr = 0; m_passes = 0; m_data = '0; m_valid = 1'b0;
    end else begin
      m_valid = (m_mode == M_PLAY) && ce;
      if (m_valid) begin
        w = m_mem[m_addr];
        m_data = w[DATA_W-1:0];
      end
      if (wr_en) m_mem[int'(wa)] = wd;
      if (stop) begin
        if (m_mode != M_IDLE) begin m_mode = M_IDLE; m_addr = 0; end
      end else if (start) begin
        m_mode = M_PLAY; m_addr = 0; m_passes = 0;
      end else if (m_valid) begin
        if (m_addr == int'(last)) begin
          m_passes = (m_passes < 65535) ? m_passes + 1 : 65535;
          m_addr = 0;
          if (!loop_m) m_mode = M_DONE;
        end else begin
          m_addr = (m_addr + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("data",   32'(play_data),   32'(m_data));
      check("valid",  32'(play_valid),  32'(m_valid));
      check("busy",   32'(play_busy),   32'(m_mode == M_PLAY));
      check("done",   32'(play_done),   32'(m_mode == M_DONE));
      check("passes", 32'(play_passes), 32'(m_passes));
      if (play_valid === 1'b1) got.push_back(32'(play_data));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1; wa = ADDR_W'(a); wd = d; step(1); wr_en = 1'b0;
  endtask
  task automatic pulse_start(); start = 1'b1; step(1); start = 1'b0; endtask
  task automatic pulse_stop();  stop  = 1'b1; step(1); stop  = 1'b0; endtask
  task automatic pulse_ce();    ce    = 1'b1; step(1); ce    = 1'b0; endtask

  task automatic check_got(input string nm);
    check({nm, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", nm, i), got[i], exp_q[i]);
    got.delete();
  endtask

  initial begin
    step(2);
    rst = 1'b0; chk_en = 1;
    check("rst_data", 32'(play_data), 32'h0);
    check("rst_passes", 32'(play_passes), 32'h0);

    // one-shot
    wr(0, 32'h005); wr(1, 32'h3FF); wr(2, 32'h400); wr(3, 32'h7FF);
    last = 3; loop_m = 0; got.delete();
    pulse_start();
    ce = 1'b1; step(5); ce = 1'b0; step(2);
    exp_q = '{32'h005, 32'h3FF, 32'h400, 32'h7FF}; check_got("oneshot");
    check("oneshot_passes", 32'(play_passes), 32'd1);
    check("oneshot_done", 32'(play_done), 32'd1);
    check("oneshot_busy", 32'(play_busy), 32'd0);

    // looped, sparse ce
    loop_m = 1; pulse_start();
    for (int i = 0; i < 10; i++) begin pulse_ce(); step(2); end
    step(1);
    exp_q = '{32'h005, 32'h3FF, 32'h400, 32'h7FF, 32'h005, 32'h3FF, 32'h400, 32'h7FF,
              32'h005, 32'h3FF};
    check_got("loop");
    check("loop_passes", 32'(play_passes), 32'd2);
    check("loop_busy", 32'(play_busy), 32'd1);

    // truncation with a 1-word table
    pulse_stop(); wr(0, 32'hFFFF_F80A); last = 0; loop_m = 0;
    pulse_start(); pulse_ce(); step(2);
    exp_q = '{32'h00A}; check_got("trunc");
    check("trunc_passes", 32'(play_passes), 32'd1);

    // stop mid-loop then restart
    wr(0, 32'h005); last = 3; loop_m = 1; pulse_start();
    ce = 1'b1; step(6); ce = 1'b0; pulse_stop(); step(2);
    exp_q = '{32'h005, 32'h3FF, 32'h400, 32'h7FF, 32'h005, 32'h3FF}; check_got("stop");
    check("stop_busy", 32'(play_busy), 32'd0);
    check("stop_passes_held", 32'(play_passes), 32'd1);
    pulse_start(); check("restart_passes", 32'(play_passes), 32'd0);
    pulse_ce(); step(2);
    exp_q = '{32'h005}; check_got("restart");

    // start+stop together from IDLE, then ce ignored in DONE
    pulse_stop(); start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(play_busy), 32'd0);
    last = 0; loop_m = 0; pulse_start(); pulse_ce(); step(2); got.delete();
    ce = 1'b1; step(3); ce = 1'b0; step(1);
    exp_q = {}; check_got("done_ce");
    check("done_hold", 32'(play_done), 32'd1);
    pulse_start(); pulse_ce(); step(2);
    exp_q = '{32'h005}; check_got("done_restart");

    // reset mid-loop, RAM preserved
    last = 3; loop_m = 1; pulse_start();
    ce = 1'b1; step(2); rst = 1'b1; step(1); rst = 1'b0; ce = 1'b0;
    check("srst_data", 32'(play_data), 32'h0);
    check("srst_valid", 32'(play_valid), 32'h0);
    check("srst_busy", 32'(play_busy), 32'h0);
    check("srst_passes", 32'(play_passes), 32'h0);
    got.delete();
    pulse_start(); ce = 1'b1; step(4); ce = 1'b0; step(2);
    exp_q = '{32'h005, 32'h3FF, 32'h400, 32'h7FF}; check_got("after_rst");

    // read-first collision on address 1
    pulse_stop(); pulse_start();
    ce = 1'b1; step(1);
    wr(1, 32'h123);
    step(4); ce = 1'b0; step(2);
    exp_q = '{32'h005, 32'h3FF, 32'h400, 32'h7FF, 32'h005, 32'h123}; check_got("rdfirst");

    // pass counter saturation
    pulse_stop(); last = 0; loop_m = 1; pulse_start();
    ce = 1'b1; step(65540); ce = 1'b0; step(1);
    check("sat_passes", 32'(play_passes), 32'hFFFF);
    check("sat_busy", 32'(play_busy), 32'd1);
    got.delete();

    pulse_stop(); step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bram_player.md
Name: bram_player

Overview:
- Stimulus playback buffer: the micro loads a table of 32-bit words into a dual-port RAM, and the block streams them into the DSP datapath one word per sample strobe.
- It is the injection-side counterpart of the log RAM: the log RAM has the DSP writing and the micro reading, while this block has the micro writing and the DSP reading.
- It sits on clockdsp between the micro register interface and the equalizer input mux. Supports one-shot and looped playback.

Parameters:
- ADDR_W, 15, RAM address width.
- DEPTH, 32768, RAM depth in words (2**ADDR_W).
- DATA_W, 11, width of play_data; the low DATA_W bits of each RAM word are output.

Ports:
- clockdsp  in  1  DSP clock; all logic on the rising edge.
- soft_reset  in  1  synchronous, active-high reset.
- play_wr_en_from_micro  in  1  RAM write strobe; one word written per high cycle.
- play_wr_addr_from_micro  in  ADDR_W  RAM write address.
- play_wr_data_from_micro  in  32  RAM write data.
- play_start_from_micro  in  1  single-cycle pulse that starts or restarts playback.
- play_stop_from_micro  in  1  single-cycle pulse that aborts playback.
- play_last_addr_from_micro  in  ADDR_W  index of the last table word; table length is this value + 1.
- play_loop_from_micro  in  1  1 = wrap to address 0 after the last word; 0 = one-shot.
- play_ce  in  1  DSP sample strobe; one read is issued per high cycle while playing.
- play_data  out  DATA_W  current sample; holds its value between reads.
- play_valid  out  1  one-cycle pulse when play_data is updated.
- play_busy  out  1  high in state PLAY.
- play_done  out  1  high in state DONE.
- play_passes  out  16  completed full passes through the table; saturates at 65535.

Behaviour:
- Reset (soft_reset=1, checked on the clock edge) has priority over everything else:
  - state=IDLE, read address=0.
  - play_data=0, play_valid=0, play_busy=0, play_done=0, play_passes=0.
  - RAM contents are not cleared.
  - A reset in the middle of playback aborts it immediately.
- RAM:
  - Port A is micro write only; port B is DSP read only.
  - Read is synchronous with 1-cycle latency.
  - Writes are accepted in every state.
  - Same-address write and read in the same cycle is read-first: the read returns the old word.
- FSM states: IDLE, PLAY, DONE.
  - IDLE: start -> PLAY, read address=0, play_passes=0.
  - PLAY: on play_ce=1, issue a read at the current address, then:
    - if address < play_last_addr_from_micro: address+1.
    - if address == play_last_addr_from_micro: play_passes+1 (saturating). If play_loop_from_micro=1, address=0 and stay in PLAY. If 0, go to DONE.
  - DONE: start -> PLAY, address=0, play_passes=0.
  - Stop in PLAY or DONE -> IDLE, address=0. play_passes is held.
  - Start and stop asserted in the same cycle: stop wins.
  - Start while already in PLAY: restart at address 0, play_passes=0. A read issued in that same cycle still completes.
- play_last_addr_from_micro and play_loop_from_micro are sampled each cycle and compared live. If last_addr is lowered below the current address, playback runs to DEPTH-1, where the address naturally wraps to 0, and then terminates when the address matches last_addr. No special handling is provided.
- Output timing: a play_ce accepted at cycle N (state PLAY) reading address A gives:
  - play_data = mem[A][DATA_W-1:0] at cycle N+1.
  - play_valid = 1 for cycle N+1 only.
  - In-flight reads complete even if the state leaves PLAY (DONE, or IDLE via stop).
- play_ce is ignored in IDLE and DONE: no read, no address change.
- play_busy = (state==PLAY) and play_done = (state==DONE), both registered with the state.
- play_last_addr_from_micro = 0 plays a 1-word table: each ce outputs mem[0]. In loop mode each ce also increments play_passes.
- Throughput: one sample per cycle when play_ce is held high.

Test Plan:
- Load and one-shot:
  - Stimulus: write mem[0..3] = 0x005, 0x3FF, 0x400, 0x7FF; last_addr=3; loop=0; start; hold play_ce=1.
  - Response: play_valid for 4 consecutive cycles carrying 0x005, 0x3FF, 0x400, 0x7FF; first valid arrives 1 cycle after the first ce. play_done=1 and play_busy=0 after the 4th read. play_passes=1.
- Loop wrap:
  - Stimulus: same table, loop=1; 10 ce pulses spaced 3 cycles apart.
  - Response: outputs 5, 3FF, 400, 7FF, 5, 3FF, 400, 7FF, 5, 3FF. play_passes=2. play_busy stays 1.
- Truncation:
  - Stimulus: mem[0] = 0xFFFF_F80A, last_addr=0, one ce.
  - Response: play_data = 0x00A with DATA_W=11, and play_passes=1.
- Stop and restart:
  - Stimulus: stop after the 2nd ce; then start.
  - Response: the 2nd valid still appears. State goes IDLE with play_busy=0 and play_passes held. After the restart, the next ce returns mem[0].
- Simultaneous and ignored controls:
  - Stimulus: start and stop in the same cycle from IDLE.
  - Response: stays in IDLE.
  - Stimulus: ce pulses while in DONE.
  - Response: no play_valid and no address change.
- Reset and read-first:
  - Stimulus: soft_reset mid-loop.
  - Response: all outputs 0 the next cycle; RAM preserved, so a subsequent start replays the same data.
  - Stimulus: write mem[1] in the same cycle as the ce that reads address 1.
  - Response: old word returned; new word returned on the next pass.
